instr_fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the 128x8 synchronous program ROM.
- Owns the program counter and drives the ROM address.
- Absorbs the ROM's one-cycle read latency and assembles 1- or 2-byte instructions (opcode plus optional operand).
- Hands complete instructions to the decode/execute stage over a valid/ready handshake, and accepts branch redirects from it.

---
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, drives the 128x8 sync ROM, assembles
// 1/2-byte instructions and hands them to execute over valid/ready.
// Ports: clk, reset (async, active-low); rom_addr/rom_data to ROM;
//   opcode/operand/instr_pc/instr_valid, instr_ready, redirect,
//   redirect_target to execute; fetch_fault bounds fault.
// Optional macro FETCH_BOUNDS_CHECK_EN enables the ROM bounds check.

`ifndef LDA_IMM
`define LDA_IMM 8'h10
`endif
`ifndef LDB_IMM
`define LDB_IMM 8'h11
`endif
`ifndef LDA_DIR
`define LDA_DIR 8'h12
`endif
`ifndef LDB_DIR
`define LDB_DIR 8'h13
`endif
`ifndef STA_DIR
`define STA_DIR 8'h14
`endif
`ifndef STR_DIR
`define STR_DIR 8'h15
`endif
`ifndef BEQ
`define BEQ 8'h20
`endif
`ifndef BMI
`define BMI 8'h21
`endif
`ifndef BRA
`define BRA 8'h22
`endif
`ifndef ADD_AB
`define ADD_AB 8'h30
`endif
`ifndef SUB_AB
`define SUB_AB 8'h31
`endif
`ifndef NOP
`define NOP 8'h00
`endif

module instr_fetch_unit #(
    parameter int         ROM_DEPTH    = 128,
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect,
    input  logic [7:0] redirect_target,
    output logic       fetch_fault
);

    typedef enum logic [2:0] {
        FETCH_OP,
        WAIT_OP,
        FETCH_OPR,
        WAIT_OPR,
        VALID,
        HALT
    } state_t;

    localparam logic [8:0] LIMIT = 9'(ROM_DEPTH);

    state_t     state;
    logic [7:0] pc;
    logic       fault_q;
    logic       check_en;
    logic       oob;
    logic       two_byte;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign check_en = 1'b1;
`else
    assign check_en = 1'b0;
`endif

    assign rom_addr    = pc;
    assign oob         = check_en && ({1'b0, pc} >= LIMIT);
    assign fetch_fault = fault_q;

    // Length decode on the byte arriving from the ROM this cycle.
    always_comb begin
        two_byte = 1'b0;
        case (rom_data)
            `LDA_IMM, `LDB_IMM, `LDA_DIR, `LDB_DIR,
            `STA_DIR, `STR_DIR, `BEQ, `BMI, `BRA:
                two_byte = 1'b1;
            default:
                two_byte = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH_OP;
            pc          <= RESET_VECTOR;
            opcode      <= 8'h00;
            operand     <= 8'h00;
            instr_pc    <= 8'h00;
            instr_valid <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            unique case (state)
                FETCH_OP: begin
                    if (oob) begin
                        fault_q <= 1'b1;
                        state   <= HALT;
                    end else begin
                        instr_pc <= pc;
                        state    <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    opcode <= rom_data;
                    pc     <= pc + 8'd1;
                    if (two_byte) begin
                        state <= FETCH_OPR;
                    end else begin
                        operand     <= 8'h00;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                end
                FETCH_OPR: begin
                    if (oob) begin
                        fault_q <= 1'b1;
                        state   <= HALT;
                    end else begin
                        state <= WAIT_OPR;
                    end
                end
                WAIT_OPR: begin
                    operand     <= rom_data;
                    pc          <= pc + 8'd1;
                    instr_valid <= 1'b1;
                    state       <= VALID;
                end
                VALID: begin
                    // Redirect only counts on an actual handshake.
                    if (instr_ready) begin
                        if (redirect) begin
                            pc <= redirect_target;
                        end
                        instr_valid <= 1'b0;
                        state       <= FETCH_OP;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH_OP;
                end
            endcase
        end
    end

endmodule
